// File: rtl/store_unit_if.sv
// Data-memory write bus between the store unit (master) and data memory (slave).
//   mem_req   master->slave  beat request, held until mem_ack
//   mem_we    master->slave  write strobe, mirrors mem_req
//   mem_addr  master->slave  word-aligned beat address
//   mem_wdata master->slave  lane-shifted write data, unselected lanes zero
//   mem_be    master->slave  byte enables, bit i = byte lane i
//   mem_ack   slave->master  one-cycle accept of the current beat
interface store_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_be;
  logic            mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack
  );
endinterface

// File: rtl/store_unit.sv
// Store unit: takes one SB/SH/SW request from the core, computes byte enables
// and lane-shifted data, splits misaligned accesses into two aligned beats and
// runs the req/ack handshake to data memory with a per-beat timeout.
//   clk, rst_n   clock, asynchronous active-low reset
//   st_req       store request (sampled only when idle)
//   st_funct3    000 SB, 001 SH, 010 SW; anything else is illegal
//   st_addr      byte address
//   st_data      rs2 value; low byte/half/word is stored
//   st_busy      store in flight, core stalls
//   st_done      one-cycle pulse when the store has committed
//   st_err       one-cycle pulse on illegal funct3 or timeout
//   mem          data-memory write bus (master side)
module store_unit #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            st_req,
  input  logic [2:0]      st_funct3,
  input  logic [XLEN-1:0] st_addr,
  input  logic [XLEN-1:0] st_data,
  output logic            st_busy,
  output logic            st_done,
  output logic            st_err,
  store_unit_if.master    mem
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t            state, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic [2:0]        f3_q, f3_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              req_q, req_d;
  logic [XLEN-1:0]   maddr_q, maddr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              busy_d, done_d, err_d;

  logic [XLEN-1:0]   src_addr, src_data, data_sel, base;
  logic [2:0]        src_f3;
  logic [1:0]        off;
  logic [3:0]        mask;
  logic [7:0]        be8;
  logic [2*XLEN-1:0] d64;
  logic              two_beat, legal_f3, timed_out;

  // Lane math: while idle it works on the incoming request, afterwards on the captured one
  always_comb begin
    src_addr = (state == IDLE) ? st_addr   : addr_q;
    src_data = (state == IDLE) ? st_data   : data_q;
    src_f3   = (state == IDLE) ? st_funct3 : f3_q;
    case (src_f3)
      3'b000:  mask = 4'b0001;
      3'b001:  mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    off      = src_addr[1:0];
    data_sel = src_data & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    be8      = 8'({4'b0000, mask} << off);
    d64      = {{XLEN{1'b0}}, data_sel} << {off, 3'b000};
    base     = {src_addr[XLEN-1:2], 2'b00};
    two_beat = |be8[7:4];
  end

  assign legal_f3  = (st_funct3 == 3'b000) || (st_funct3 == 3'b001) || (st_funct3 == 3'b010);
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next state, captured request, timeout counter and next registered outputs
  always_comb begin
    state_d = state;
    addr_d  = addr_q;
    data_d  = data_q;
    f3_d    = f3_q;
    cnt_d   = CNT_W'(0);
    req_d   = 1'b0;
    maddr_d = XLEN'(0);
    wdata_d = XLEN'(0);
    be_d    = 4'b0000;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state)
      IDLE: begin
        if (st_req) begin
          if (legal_f3) begin
            state_d = BEAT0;
            addr_d  = st_addr;
            data_d  = st_data;
            f3_d    = st_funct3;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      BEAT0, BEAT1: begin
        // ack wins over expiry in the same cycle
        if (mem.mem_ack) begin
          if (state == BEAT0 && two_beat) begin
            state_d = BEAT1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else if (timed_out) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      BEAT0: begin
        req_d   = 1'b1;
        maddr_d = base;
        be_d    = be8[3:0];
        wdata_d = d64[XLEN-1:0];
      end
      BEAT1: begin
        req_d   = 1'b1;
        maddr_d = base + XLEN'(4);
        be_d    = be8[7:4];
        wdata_d = d64[2*XLEN-1:XLEN];
      end
      default: ;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      f3_q    <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      st_busy <= 1'b0;
      st_done <= 1'b0;
      st_err  <= 1'b0;
    end else begin
      state   <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      f3_q    <= f3_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      st_busy <= busy_d;
      st_done <= done_d;
      st_err  <= err_d;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = req_q;
  assign mem.mem_addr  = maddr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_be    = be_q;

endmodule

// File: tb/tb_store_unit.sv
// Testbench for store_unit: expected bus beats come from a byte-by-byte model
// and are queued at request time, then popped as the DUT presents each beat.
module tb_store_unit;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        st_req;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_busy;
  logic        st_done;
  logic        st_err;

  store_unit_if #(.XLEN(32)) mem_bus ();

  store_unit #(.XLEN(32), .TIMEOUT(255)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_req    (st_req),
    .st_funct3 (st_funct3),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_busy   (st_busy),
    .st_done   (st_done),
    .st_err    (st_err),
    .mem       (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;
  beat_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
  endtask

  // Reference: place each stored byte individually into its word and lane
  task automatic build(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    beat_t b0, b1;
    int    sz;
    int    p;
    sz = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
    b0 = '0;
    b1 = '0;
    b0.addr = a & 32'hFFFF_FFFC;
    b1.addr = b0.addr + 32'd4;
    for (int i = 0; i < sz; i++) begin
      p = int'(a[1:0]) + i;
      if (p < 4) begin
        b0.be[p] = 1'b1;
        b0.wdata[8*p +: 8] = d[8*i +: 8];
      end else begin
        b1.be[p-4] = 1'b1;
        b1.wdata[8*(p-4) +: 8] = d[8*i +: 8];
      end
    end
    exp_q.push_back(b0);
    if (b1.be != 4'b0000) exp_q.push_back(b1);
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    st_req    = 1'b1;
    st_funct3 = f3;
    st_addr   = a;
    st_data   = d;
    @(negedge clk);
    st_req    = 1'b0;
  endtask

  task automatic check_beat(input string tag, input beat_t e);
    check({tag, "_req"},   32'(mem_bus.mem_req), 32'd1);
    check({tag, "_we"},    32'(mem_bus.mem_we),  32'd1);
    check({tag, "_addr"},  mem_bus.mem_addr,      e.addr);
    check({tag, "_be"},    32'(mem_bus.mem_be),   32'(e.be));
    check({tag, "_wdata"}, mem_bus.mem_wdata,     e.wdata);
  endtask

  // One full store with `waits` stall cycles per beat; optional illegal st_req poke while busy
  task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input int waits, input bit poke);
    int    nb;
    beat_t e;
    build(f3, a, d);
    nb = exp_q.size();
    issue(f3, a, d);
    for (int b = 0; b < nb; b++) begin
      e = exp_q.pop_front();
      check({tag, "_busy"}, 32'(st_busy), 32'd1);
      check_beat(tag, e);
      for (int w = 0; w < waits; w++) begin
        if (poke && b == 0 && w == 0) begin
          st_req    = 1'b1;
          st_funct3 = 3'b100;
          st_addr   = 32'hDEAD_BEE0;
        end
        @(negedge clk);
        st_req = 1'b0;
        check({tag, "_hold"}, 32'(st_err), 32'd0);
        check_beat({tag, "_stable"}, e);
      end
      mem_bus.mem_ack = 1'b1;
      @(negedge clk);
      mem_bus.mem_ack = 1'b0;
    end
    check({tag, "_done"},     32'(st_done),         32'd1);
    check({tag, "_noerr"},    32'(st_err),          32'd0);
    check({tag, "_idlebusy"}, 32'(st_busy),         32'd0);
    check({tag, "_idlereq"},  32'(mem_bus.mem_req), 32'd0);
    @(negedge clk);
    check({tag, "_donepulse"}, 32'(st_done), 32'd0);
  endtask

  initial begin
    beat_t e;
    int    n;
    logic [2:0] rf3;

    rst_n = 1'b0;
    st_req = 1'b0;
    st_funct3 = 3'b000;
    st_addr = '0;
    st_data = '0;
    mem_bus.mem_ack = 1'b0;
    #1;
    check("rst_req",  32'(mem_bus.mem_req), 32'd0);
    check("rst_be",   32'(mem_bus.mem_be),   32'd0);
    check("rst_busy", 32'(st_busy),          32'd0);
    check("rst_done", 32'(st_done),          32'd0);
    check("rst_err",  32'(st_err),           32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ack while idle is ignored
    mem_bus.mem_ack = 1'b1;
    @(negedge clk);
    mem_bus.mem_ack = 1'b0;
    check("idleack_req",  32'(mem_bus.mem_req), 32'd0);
    check("idleack_done", 32'(st_done),         32'd0);

    run_store("sb103",  3'b000, 32'h0000_0103, 32'hAABB_CCDD, 0, 1'b0);
    run_store("sw200",  3'b010, 32'h0000_0200, 32'h1234_5678, 3, 1'b1);
    run_store("sw302",  3'b010, 32'h0000_0302, 32'h1122_3344, 0, 1'b0);
    run_store("shwrap", 3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF, 1, 1'b0);
    for (int o = 0; o < 4; o++) begin
      run_store("sboff", 3'b000, 32'h0000_0500 + 32'(o), 32'h8765_4321, 0, 1'b0);
      run_store("shoff", 3'b001, 32'h0000_0600 + 32'(o), 32'hCAFE_F00D, 0, 1'b0);
      run_store("swoff", 3'b010, 32'h0000_0700 + 32'(o), 32'h0102_0304, 0, 1'b0);
    end

    // illegal funct3: error pulse, no bus activity
    issue(3'b100, 32'h0000_0800, 32'hFFFF_FFFF);
    check("ill_err",  32'(st_err),           32'd1);
    check("ill_req",  32'(mem_bus.mem_req),  32'd0);
    check("ill_busy", 32'(st_busy),          32'd0);
    @(negedge clk);
    check("ill_errpulse", 32'(st_err),          32'd0);
    check("ill_req2",     32'(mem_bus.mem_req), 32'd0);

    // timeout: ack never arrives
    issue(3'b010, 32'h0000_0900, 32'h5555_AAAA);
    check("to_addr", mem_bus.mem_addr,      32'h0000_0900);
    check("to_be",   32'(mem_bus.mem_be),   32'hF);
    n = 0;
    while (mem_bus.mem_req && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("to_cycles", 32'(n),          32'd255);
    check("to_err",    32'(st_err),     32'd1);
    check("to_busy",   32'(st_busy),    32'd0);
    check("to_nodone", 32'(st_done),    32'd0);
    @(negedge clk);
    check("to_errpulse", 32'(st_err), 32'd0);

    // reset during the second beat of a split SW
    build(3'b010, 32'h0000_0302, 32'h1122_3344);
    issue(3'b010, 32'h0000_0302, 32'h1122_3344);
    e = exp_q.pop_front();
    check_beat("rb0", e);
    mem_bus.mem_ack = 1'b1;
    @(negedge clk);
    mem_bus.mem_ack = 1'b0;
    e = exp_q.pop_front();
    check_beat("rb1", e);
    #1 rst_n = 1'b0;
    #1;
    check("rb_req",  32'(mem_bus.mem_req), 32'd0);
    check("rb_busy", 32'(st_busy),         32'd0);
    check("rb_done", 32'(st_done),         32'd0);
    check("rb_err",  32'(st_err),          32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rb_post_done", 32'(st_done),         32'd0);
    check("rb_post_req",  32'(mem_bus.mem_req), 32'd0);
    run_store("rb_sb", 3'b000, 32'h0000_0A02, 32'h0000_0077, 0, 1'b0);

    // random legal stores
    for (int k = 0; k < 20; k++) begin
      rf3 = 3'($urandom_range(0, 2));
      run_store("rnd", rf3, $urandom, $urandom, int'($urandom_range(0, 2)), 1'b0);
    end

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
